// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for pipe_stage_skid: upstream/downstream valid-ready
// pairs, datapath/control payloads, flush and occupancy.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        count;

  modport master (
    output flush, in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, count
  );

  modport slave (
    input  flush, in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, count
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// One-cycle pipeline register stage. Define PIPE_STAGE_SKID_EN for a
// two-entry skid buffer with registered in_ready; otherwise single entry.
module pipe_stage_skid #(
  parameter int                DATA_W      = 32,
  parameter int                CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '1
) (
  input logic               clk,
  input logic               rst,
  pipe_stage_skid_if.slave  pipe
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
`ifdef PIPE_STAGE_SKID_EN
  localparam logic [1:0] FULL  = 2'd2;
`endif

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic              rdy_q, rdy_d;
  logic              in_ready;
  logic              out_valid;
  logic              accept;
  logic              drain;
`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
`endif

  always_comb begin
    out_valid = (state_q != EMPTY);
`ifdef PIPE_STAGE_SKID_EN
    in_ready  = rdy_q;
`else
    // rdy_q only marks "out of reset" here, keeping in_ready low under rst
    in_ready  = rdy_q && (pipe.out_ready || !out_valid);
`endif
    accept    = pipe.in_valid && in_ready;
    drain     = out_valid && pipe.out_ready;
  end

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_data_d = pipe.in_data;
          main_ctrl_d = pipe.in_ctrl;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          main_data_d = pipe.in_data;
          main_ctrl_d = pipe.in_ctrl;
        end else if (accept) begin
          skid_data_d = pipe.in_data;
          skid_ctrl_d = pipe.in_ctrl;
          state_d     = FULL;
        end else if (drain) begin
          state_d     = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
          state_d     = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (pipe.flush) state_d = EMPTY;
    rdy_d = (state_d != FULL);
`else
    if (accept) begin
      main_data_d = pipe.in_data;
      main_ctrl_d = pipe.in_ctrl;
      state_d     = ONE;
    end else if (drain) begin
      state_d     = EMPTY;
    end
    if (pipe.flush) state_d = EMPTY;
    rdy_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= CTRL_BUBBLE;
      rdy_q       <= 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      skid_data_q <= '0;
      skid_ctrl_q <= CTRL_BUBBLE;
`endif
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      rdy_q       <= rdy_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
`endif
    end
  end

  assign pipe.in_ready  = in_ready;
  assign pipe.out_valid = out_valid;
  assign pipe.out_data  = out_valid ? main_data_q : '0;
  assign pipe.out_ctrl  = out_valid ? main_ctrl_q : CTRL_BUBBLE;
  assign pipe.count     = state_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomized checks for pipe_stage_skid in either build of
// PIPE_STAGE_SKID_EN (expectations follow the same macro).
module tb_pipe_stage_skid;
  localparam int DW = 32;
  localparam int CW = 16;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

  pipe_stage_skid #(
    .DATA_W      (DW),
    .CTRL_W      (CW),
    .CTRL_BUBBLE (16'hFFFF)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .pipe (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic offer(input logic [31:0] d);
    bus.in_data = d;
    bus.in_ctrl = d[15:0];
  endtask

  task automatic fill();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    offer(32'hE1);
    tick();
    offer(32'hE2);
    tick();
    bus.in_valid  = 1'b0;
    chk("fill_count", bus.count, CAP);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, bus.count, 0);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_data"},  bus.out_data, 0);
    chk({tag, "_ctrl"},  bus.out_ctrl, 16'hFFFF);
    chk({tag, "_ready"}, bus.in_ready, 0);
  endtask

  logic [47:0] q[$];
  logic        exp_valid, exp_ready, acc, drn;

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_data = '0; bus.in_ctrl = '0;
    #3;
    chk_reset_vals("rst");
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rel_ready_low", bus.in_ready, 0);
    tick();
    chk("rel_ready_high", bus.in_ready, 1);

    // single transfer, 1-cycle latency
    bus.out_ready = 1'b1;
    bus.in_data = 32'h1234; bus.in_ctrl = 16'h0005; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("single_valid", bus.out_valid, 1);
    chk("single_data",  bus.out_data, 32'h1234);
    chk("single_ctrl",  bus.out_ctrl, 16'h0005);
    chk("single_count", bus.count, 1);
    tick();
    chk("single_drain_valid", bus.out_valid, 0);
    chk("single_drain_ctrl",  bus.out_ctrl, 16'hFFFF);
    chk("single_drain_data",  bus.out_data, 0);
    chk("single_drain_count", bus.count, 0);

    // back-to-back stream
    for (int i = 1; i <= 8; i++) begin
      bus.in_valid = 1'b1;
      offer(i);
      #1;
      chk("stream_ready", bus.in_ready, 1);
      tick();
      chk("stream_valid", bus.out_valid, 1);
      chk("stream_data",  bus.out_data, i);
      chk("stream_count", bus.count, 1);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("stream_end_count", bus.count, 0);

    // back-pressure
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    offer(32'hA);
    tick();
    chk("bp_a_count", bus.count, 1);
    chk("bp_a_data",  bus.out_data, 32'hA);
    offer(32'hB);
`ifdef PIPE_STAGE_SKID_EN
    #1;
    chk("bp_b_ready", bus.in_ready, 1);
    tick();
    chk("bp_full_count", bus.count, 2);
    chk("bp_full_ready", bus.in_ready, 0);
    chk("bp_full_data",  bus.out_data, 32'hA);
    offer(32'hC);
    tick();
    chk("bp_hold_count", bus.count, 2);
    chk("bp_hold_data",  bus.out_data, 32'hA);
    chk("bp_hold_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_out_b", bus.out_data, 32'hB);
    chk("bp_out_b_count", bus.count, 1);
    chk("bp_out_b_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_out_c", bus.out_data, 32'hC);
    chk("bp_out_c_count", bus.count, 1);
`else
    #1;
    chk("bp_b_ready", bus.in_ready, 0);
    tick();
    chk("bp_hold_count", bus.count, 1);
    chk("bp_hold_data",  bus.out_data, 32'hA);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.in_ready, 1);
    tick();
    chk("bp_out_b", bus.out_data, 32'hB);
    chk("bp_out_b_count", bus.count, 1);
    offer(32'hC);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_out_c", bus.out_data, 32'hC);
`endif
    tick();
    chk("bp_end_count", bus.count, 0);

    // flush discards held entries and the entry offered alongside it
    fill();
    bus.flush = 1'b1; bus.in_valid = 1'b1;
    offer(32'hD);
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_count", bus.count, 0);
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_ctrl",  bus.out_ctrl, 16'hFFFF);
    chk("flush_data",  bus.out_data, 0);
    chk("flush_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_no_d", bus.out_valid, 0);
    end

    // asynchronous reset mid-cycle while holding entries
    fill();
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    tick();
    rst = 1'b0;
    #1;
    chk("async_rel_low", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    tick();
    chk("async_rel_high", bus.in_ready, 1);
    chk("async_rel_count", bus.count, 0);

    // randomized traffic against a queue model
    for (int cyc = 0; cyc < 10000; cyc++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_data   = $urandom;
      bus.in_ctrl   = 16'($urandom);
      #1;
      exp_valid = (q.size() != 0);
`ifdef PIPE_STAGE_SKID_EN
      exp_ready = (q.size() < CAP);
`else
      exp_ready = bus.out_ready || !exp_valid;
`endif
      chk("rnd_count", bus.count, q.size());
      chk("rnd_valid", bus.out_valid, exp_valid);
      chk("rnd_ready", bus.in_ready, exp_ready);
      if (exp_valid) begin
        chk("rnd_data", bus.out_data, q[0][31:0]);
        chk("rnd_ctrl", bus.out_ctrl, q[0][47:32]);
      end else begin
        chk("rnd_bubble", bus.out_ctrl, 16'hFFFF);
      end
      acc = bus.in_valid && exp_ready;
      drn = exp_valid && bus.out_ready;
      if (drn) void'(q.pop_front());
      if (acc) q.push_back({bus.in_ctrl, bus.in_data});
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32: width of the datapath payload (result/operand words).
REQ-002 The block SHALL take parameter CTRL_W, default 16: width of the control payload (write-enable, load/store type, writeback fields).
REQ-003 The block SHALL take parameter CTRL_BUBBLE, default all-ones in CTRL_W bits: the no-op control encoding presented whenever the output is invalid.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 flush  input  1  synchronous squash of all held entries.
REQ-007 in_valid  input  1  upstream entry present.
REQ-008 in_ready  output  1  stage accepts the entry this cycle.
REQ-009 in_data  input  DATA_W  upstream datapath payload.
REQ-010 in_ctrl  input  CTRL_W  upstream control payload.
REQ-011 out_valid  output  1  entry presented downstream.
REQ-012 out_ready  input  1  downstream accepts the entry this cycle.
REQ-013 out_data  output  DATA_W  held datapath payload.
REQ-014 out_ctrl  output  CTRL_W  held control payload, or CTRL_BUBBLE when out_valid=0.
REQ-015 count  output  2  number of entries held (0..2).

Function
REQ-016 An entry SHALL transfer in when in_valid&&in_ready and out when out_valid&&out_ready, both sampled at the rising edge.
REQ-017 Latency SHALL be exactly 1 cycle: an entry accepted into an empty stage appears on out_* the next cycle.
REQ-018 Entries SHALL leave in acceptance order; no entry is duplicated or dropped except by flush.
REQ-019 out_ctrl SHALL equal CTRL_BUBBLE and out_data SHALL equal 0 whenever out_valid=0.
REQ-020 The state machine SHALL have states EMPTY (count 0), ONE (count 1, main register valid), FULL (count 2, main and skid registers valid).
REQ-021 EMPTY->ONE on accept; ONE->EMPTY on drain with no accept; ONE stays ONE on simultaneous accept and drain; ONE->FULL on accept with out_ready=0; FULL->ONE on drain (skid entry moves to main register).
REQ-022 In FULL, in_ready SHALL be 0; in EMPTY and ONE, in_ready SHALL be 1; in_ready SHALL be a register output, not a function of out_ready.
REQ-023 Payload SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 flush=1 SHALL move the stage to EMPTY on the next edge, with count=0 and out_valid=0, regardless of in_valid or out_ready in that cycle; an entry offered in the flush cycle SHALL be discarded.
REQ-025 count SHALL never exceed 2; in_valid while in_ready=0 SHALL have no effect.

Reset
REQ-026 While rst=1, count SHALL be 0, out_valid 0, out_data 0, out_ctrl CTRL_BUBBLE and in_ready 0, asynchronously.
REQ-027 in_ready SHALL rise on the first edge after rst deasserts; reset asserted mid-transfer SHALL discard all entries.

Configuration
REQ-028 Macro PIPE_STAGE_SKID_EN SHALL select the skid buffer.
REQ-029 Defined: behaviour SHALL be as in REQ-020..REQ-022 (two entries, registered in_ready, full throughput).
REQ-030 Undefined: the block SHALL hold a single entry; in_ready SHALL be the combinational term out_ready||!out_valid; count SHALL be 0..1; state FULL SHALL not exist; all other requirements SHALL hold unchanged.

Verification
REQ-031 Reset then in_data=0x1234, in_ctrl=0x0005, in_valid=1 for one cycle, out_ready=1 -> out_valid=1 with 0x1234/0x0005 one cycle later, then out_valid=0 with out_ctrl=0xFFFF.
REQ-032 Stream 0x1..0x8 back-to-back with out_ready=1 -> 8 consecutive valid outputs in order, in_ready stays 1, count stays 1.
REQ-033 out_ready=0, offer 0xA, 0xB, 0xC -> 0xA and 0xB accepted, count=2, in_ready=0, 0xC held upstream; raise out_ready -> 0xA, 0xB, 0xC out in order.
REQ-034 count=2, assert flush with in_valid=1 (0xD) -> next cycle count=0, out_valid=0, out_ctrl=0xFFFF; 0xD never appears.
REQ-035 Assert rst asynchronously mid-cycle with count=2 -> outputs reach reset values before the next edge; in_ready returns to 1 one edge after release.
REQ-036 Random in_valid/out_ready at 50% over 10000 cycles, both macro settings -> scoreboard matches, no loss or reorder, payload stable under back-pressure.
